// File: rtl/ring_inject.sv
// Ring slot injector: forwards ring flits with one cycle of latency and fills
// empty slots from a local FIFO, flagging starvation when the ring stays busy.
module ring_inject #(
  parameter int W          = 144,
  parameter int VALID_BIT  = 0,
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             ring_ci,
  input  logic                     inj_valid,
  input  logic [W-1:0]             inj_data,
  output logic                     inj_ready,
  output logic [W-1:0]             ring_co,
  output logic                     sel_co,
  output logic [$clog2(DEPTH):0]   inj_count,
  output logic                     starve
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [7:0]    LIM_C   = 8'(STARVE_LIM);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  ring_co_q, ring_co_d;
  logic          sel_q, sel_d;
  logic [7:0]    scnt_q, scnt_d;
  logic          starve_q, starve_d;

  logic [W-1:0]  flit_s;
  logic          ready_s;
  logic          push_s;
  logic          pop_s;

  // Readiness and injection decisions use start-of-cycle state only, so a
  // pushed flit can never bypass into the slot in the same cycle.
  assign ready_s = (count_q < DEPTH_C);
  assign push_s  = inj_valid & ready_s;
  assign pop_s   = ~ring_ci[VALID_BIT] & (count_q != {CW{1'b0}});

  always_comb begin
    flit_s            = inj_data;
    flit_s[VALID_BIT] = 1'b1;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ring_co_d = ring_ci;
    sel_d     = 1'b0;
    scnt_d    = scnt_q;
    starve_d  = (scnt_q == LIM_C);

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      ring_co_d = mem_q[rd_ptr_q];
      sel_d     = 1'b1;
    end else begin
      rd_ptr_d  = rd_ptr_q;
      ring_co_d = ring_ci;
      sel_d     = 1'b0;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pop_s || (count_q == {CW{1'b0}})) begin
      scnt_d = 8'd0;
    end else if (ring_ci[VALID_BIT] && (scnt_q < LIM_C)) begin
      scnt_d = scnt_q + 8'd1;
    end else begin
      scnt_d = scnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      ring_co_q <= {W{1'b0}};
      sel_q     <= 1'b0;
      scnt_q    <= 8'd0;
      starve_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ring_co_q <= ring_co_d;
      sel_q     <= sel_d;
      scnt_q    <= scnt_d;
      starve_q  <= starve_d;
    end
  end

  // Storage is not cleared on reset; the reset pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_q[wr_ptr_q] <= flit_s;
    end
  end

  assign inj_ready = ready_s;
  assign ring_co   = ring_co_q;
  assign sel_co    = sel_q;
  assign inj_count = count_q;
  assign starve    = starve_q;

endmodule
